slave_port: RTL and testbench
=============================

// Module: slave_port
// PURPOSE
//  Bit-serial bus slave interface sitting directly downstream of the address decoder: consumes the
//  decoder's per-slave valid (mvalid) plus the serial write line, deserialises the memory address and write data,
//  drives a local synchronous memory, and serialises read data back to the master. One instance per slave.
// PARAMETERS
//  ADDR_WIDTH     12  memory address bits received serially, LSB first
//  DATA_WIDTH      8  data word bits, serial LSB first in both directions
//  SPLIT_LATENCY   4  cycles a split read holds ssplit before it may resume (SLAVE_SPLIT_EN only)
// PORTS
//  clk          in   1           bus clock, all logic on rising edge
//  rstn         in   1           asynchronous active-low reset
//  mvalid       in   1           decoder-gated valid; high for the whole frame
//  mwdata       in   1           serial address/write-data bit
//  mmode        in   1           1 = write, 0 = read; sampled with address bit 0
//  split_grant  in   1           arbiter ends split (used only with SLAVE_SPLIT_EN)
//  srdata       out  1           serial read data
//  svalid       out  1           srdata valid
//  sready       out  1           slave idle, can accept a frame
//  ssplit       out  1           split request to arbiter (tied 0 without SLAVE_SPLIT_EN)
//  mem_addr     out  ADDR_WIDTH  memory address
//  mem_wdata    out  DATA_WIDTH  memory write data
//  mem_wen      out  1           one-cycle write strobe
//  mem_ren      out  1           one-cycle read strobe; mem_rdata valid the following cycle
//  mem_rdata    in   DATA_WIDTH  memory read data
// BEHAVIOUR
//  - Reset (async): state IDLE, counter 0, all shift regs 0; srdata/svalid/ssplit/mem_wen/mem_ren 0, sready 1,
//    mem_addr/mem_wdata 0.
//  - States: IDLE, ADDR, WDATA, WRITE, RREQ, RWAIT, SPLIT (macro only), RDATA. sready = (state==IDLE).
//  - IDLE: mvalid=1 -> capture addr[0]<=mwdata, mode<=mmode, counter<=1, go ADDR.
//  - ADDR: addr[counter]<=mwdata; at counter==ADDR_WIDTH-1: counter<=0, go WDATA (write) or RREQ (read).
//  - WDATA: wdata[counter]<=mwdata; at counter==DATA_WIDTH-1 go WRITE. WRITE: mem_wen=1 one cycle, -> IDLE.
//  - RREQ: mem_ren=1 one cycle -> RWAIT. RWAIT: load mem_rdata into PISO -> RDATA (or SPLIT).
//  - RDATA: svalid=1, srdata=piso[0], shift right each cycle; DATA_WIDTH cycles, then -> IDLE.
//  - Latency: first read bit on srdata 3 cycles after last address bit sampled; write strobe 1 cycle after last data bit.
//  - Abort: mvalid=0 in ADDR, WDATA or RDATA -> IDLE next cycle, no mem_wen, svalid drops; partial data discarded.
//  - mvalid=1 while in WRITE/RREQ/RWAIT: ignored (frame continues). Counter width clog2(max(ADDR_WIDTH,DATA_WIDTH)).
//  - Back-to-back: new frame accepted the cycle after return to IDLE; mvalid held high through IDLE restarts a frame.
// CONFIGURATION
//  - `SLAVE_SPLIT_EN defined: reads go RWAIT->SPLIT; ssplit=1 in SPLIT; counter counts SPLIT_LATENCY cycles, then
//    stays until split_grant=1 -> RDATA. mvalid ignored in SPLIT and RDATA (master released the bus); split_grant
//    before latency expires is ignored. Writes never split.
//  - Undefined: SPLIT state absent, ssplit tied 0, split_grant unused, RWAIT->RDATA directly.
// STRUCTURE
//  - Shared include bus_defs.vh: state encodings, MODE_READ/MODE_WRITE constants (also used by master port).
//  - One sub-module: piso_shift (parallel load, serial LSB-first shift out) for read data.
// TESTING
//  - Write addr 0x5A3 data 0xC4 -> mem_wen one cycle, mem_addr=0x5A3, mem_wdata=0xC4, sready back to 1.
//  - mem holds 0xA5 at 0x010, read 0x010 -> mem_ren one pulse, srdata 1,0,1,0,0,1,0,1 with svalid 8 cycles.
//  - mvalid dropped after 6 address bits -> IDLE next cycle, mem_wen never asserted.
//  - rstn low mid-WDATA (async) -> outputs at reset values immediately; next full frame completes correctly.
//  - Two back-to-back writes (0x001/0x11, 0x002/0x22) -> two mem_wen pulses with correct addr/data.
//  - SLAVE_SPLIT_EN read, split_grant at cycle 2 and again at cycle 7 -> ssplit high >=4 cycles, RDATA after cycle 7.

Source files
------------

// File: rtl/slave_port_pkg.sv
// Shared state encodings and mode constants for the bit-serial slave port.
// Optional split-read support is enabled with `SLAVE_SPLIT_EN.
package slave_port_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_WDATA = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_RREQ  = 3'd4;
  localparam logic [2:0] S_RWAIT = 3'd5;
  localparam logic [2:0] S_SPLIT = 3'd6;
  localparam logic [2:0] S_RDATA = 3'd7;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/slave_port_if.sv
// Serial bus signals between master/decoder and one slave port.
// split_grant/ssplit are only active with `SLAVE_SPLIT_EN.
interface slave_port_if;

  logic mvalid;
  logic mwdata;
  logic mmode;
  logic split_grant;
  logic srdata;
  logic svalid;
  logic sready;
  logic ssplit;

  modport master (
    output mvalid, mwdata, mmode, split_grant,
    input  srdata, svalid, sready, ssplit
  );

  modport slave (
    input  mvalid, mwdata, mmode, split_grant,
    output srdata, svalid, sready, ssplit
  );

endinterface

// File: rtl/slave_port_piso_shift.sv
// Parallel-load, LSB-first serial shift-out register for read data.
// Load takes priority over shift.
module slave_port_piso_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] pdata,
  output logic         sout
);

  logic [W-1:0] sh_q, sh_d;

  always_comb begin
    sh_d = sh_q;
    if (load)
      sh_d = pdata;
    else if (shift)
      sh_d = {1'b0, sh_q[W-1:1]};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      sh_q <= '0;
    else
      sh_q <= sh_d;
  end

  assign sout = sh_q[0];

endmodule

// File: rtl/slave_port.sv
// Bit-serial bus slave: deserialises address/write data, drives a local
// synchronous memory, serialises read data. Split reads via `SLAVE_SPLIT_EN.
module slave_port
  import slave_port_pkg::*;
#(
  parameter int ADDR_WIDTH    = 12,
  parameter int DATA_WIDTH    = 8,
  parameter int SPLIT_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  slave_port_if.slave           bus,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CNT_MAX =
    max2(max2(ADDR_WIDTH, DATA_WIDTH), SPLIT_LATENCY);
  localparam int CW = $clog2(CNT_MAX);
  localparam logic [CW-1:0] A_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DATA_WIDTH - 1);

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  piso_bit;

  // Serial fields arrive LSB first; shifting in at the MSB lands them in place.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.mvalid) begin
          addr_d  = {bus.mwdata, addr_q[ADDR_WIDTH-1:1]};
          mode_d  = bus.mmode;
          cnt_d   = CW'(1);
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (!bus.mvalid) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          addr_d = {bus.mwdata, addr_q[ADDR_WIDTH-1:1]};
          if (cnt_q == A_LAST) begin
            cnt_d   = '0;
            state_d = (mode_q == MODE_READ) ? S_RREQ : S_WDATA;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_WDATA: begin
        if (!bus.mvalid) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          wdata_d = {bus.mwdata, wdata_q[DATA_WIDTH-1:1]};
          if (cnt_q == D_LAST) begin
            cnt_d   = '0;
            state_d = S_WRITE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_RREQ:  state_d = S_RWAIT;
`ifdef SLAVE_SPLIT_EN
      S_RWAIT: state_d = S_SPLIT;
      S_SPLIT: begin
        if (cnt_q != CW'(SPLIT_LATENCY - 1)) begin
          cnt_d = cnt_q + CW'(1);
        end else if (bus.split_grant) begin
          cnt_d   = '0;
          state_d = S_RDATA;
        end
      end
      S_RDATA: begin
        if (cnt_q == D_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`else
      S_RWAIT: state_d = S_RDATA;
      S_RDATA: begin
        if (!bus.mvalid || cnt_q == D_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_READ;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  slave_port_piso_shift #(
    .W (DATA_WIDTH)
  ) u_piso (
    .clk   (clk),
    .rstn  (rstn),
    .load  (state_q == S_RWAIT),
    .shift (state_q == S_RDATA),
    .pdata (mem_rdata),
    .sout  (piso_bit)
  );

  assign bus.sready = (state_q == S_IDLE);
  assign bus.svalid = (state_q == S_RDATA);
  assign bus.srdata = (state_q == S_RDATA) & piso_bit;
  assign mem_wen    = (state_q == S_WRITE);
  assign mem_ren    = (state_q == S_RREQ);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

`ifdef SLAVE_SPLIT_EN
  assign bus.ssplit = (state_q == S_SPLIT);
`else
  logic unused_split_grant;
  assign unused_split_grant = bus.split_grant;
  assign bus.ssplit = 1'b0;
`endif

endmodule

// File: tb/tb_slave_port.sv
// Randomised frame-level bench for slave_port with a reference memory model.
// Define SLAVE_SPLIT_EN to exercise the split-read path.
module tb_slave_port;

  logic        clk;
  logic        rstn;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_wen;
  logic        mem_ren;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem [0:4095];
  logic        pl_en;
  logic [11:0] pl_addr;
  logic [7:0]  pl_data;
  int          wen_cnt;
  int          ren_cnt;

  logic [7:0]  ref_mem [int];
  int          checks;
  int          errors;

  slave_port_if bus ();

  slave_port #(
    .ADDR_WIDTH    (12),
    .DATA_WIDTH    (8),
    .SPLIT_LATENCY (4)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wen   (mem_wen),
    .mem_ren   (mem_ren),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (mem_wen) begin
      mem[mem_addr] <= mem_wdata;
      wen_cnt <= wen_cnt + 1;
    end
    if (mem_ren) begin
      mem_rdata <= mem[mem_addr];
      ren_cnt <= ren_cnt + 1;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    @(negedge clk);
    pl_en   = 1'b0;
    ref_mem[int'(a)] = d;
  endtask

  // cut: bit index at which mvalid drops (-1 = none);
  // rcut: read bits delivered before mvalid drops (8 = full word).
  task automatic frame(input bit wr, input logic [11:0] a,
                       input logic [7:0] d, input int cut,
                       input int rcut, input bit hold);
    int n, sp, wen0, ren0, nbits;
    logic [7:0] rexp;
    n = 0;
    while (!bus.sready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", bus.sready, 1);
    wen0  = wen_cnt;
    ren0  = ren_cnt;
    nbits = wr ? 20 : 12;
    for (int k = 0; k < nbits; k++) begin
      if (k == cut) begin
        bus.mvalid = 1'b0;
        @(negedge clk);
        check("abort_rdy", bus.sready, 1);
        check("abort_wen", wen_cnt - wen0, 0);
        check("abort_ren", ren_cnt - ren0, 0);
        return;
      end
      bus.mvalid = 1'b1;
      bus.mmode  = wr;
      bus.mwdata = (k < 12) ? a[k] : d[k-12];
      @(negedge clk);
    end
    bus.mwdata = 1'($urandom);
    if (wr) begin
      check("wen", mem_wen, 1);
      check("waddr", mem_addr, a);
      check("wdata", mem_wdata, d);
      if (!hold) bus.mvalid = 1'b0;
      @(negedge clk);
      check("w_rdy", bus.sready, 1);
      check("wen_cnt", wen_cnt - wen0, 1);
      ref_mem[int'(a)] = d;
    end else begin
      rexp = ref_mem[int'(a)];
      check("ren", mem_ren, 1);
      @(negedge clk);
      check("ren_pulse", mem_ren, 0);
`ifdef SLAVE_SPLIT_EN
      n  = 0;
      sp = 0;
      do begin
        @(negedge clk);
        n++;
        if (bus.ssplit) sp++;
        bus.split_grant = (n == 2) || (n >= 7);
      end while (bus.ssplit && n < 30);
      bus.split_grant = 1'b0;
      check("split_cycles", sp, 7);
      rcut = 8;
`else
      sp = 0;
      @(negedge clk);
      check("ssplit0", bus.ssplit, sp);
`endif
      for (int j = 0; j < 8; j++) begin
        check("rd_valid", bus.svalid, 1);
        check("rd_bit", bus.srdata, rexp[j]);
        if (j == rcut - 1) begin
          bus.mvalid = 1'b0;
          @(negedge clk);
          check("rd_end_valid", bus.svalid, 0);
          check("rd_end_rdy", bus.sready, 1);
          check("ren_cnt", ren_cnt - ren0, 1);
          break;
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] a;
    logic [7:0]  d;
    int          c, rc;
    bit          w;
    checks          = 0;
    errors          = 0;
    rstn            = 1'b0;
    pl_en           = 1'b0;
    pl_addr         = '0;
    pl_data         = '0;
    bus.mvalid      = 1'b0;
    bus.mwdata      = 1'b0;
    bus.mmode       = 1'b0;
    bus.split_grant = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_sready", bus.sready, 1);
    check("rst_svalid", bus.svalid, 0);
    check("rst_srdata", bus.srdata, 0);
    check("rst_ssplit", bus.ssplit, 0);
    check("rst_wen", mem_wen, 0);
    check("rst_ren", mem_ren, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++)
      preload(12'h300 | 12'(i), 8'($urandom));
    preload(12'h010, 8'hA5);

    frame(1'b1, 12'h5A3, 8'hC4, -1, 8, 1'b0);
    frame(1'b0, 12'h010, 8'h00, -1, 8, 1'b0);
    frame(1'b1, 12'h3C0, 8'h99, 6, 8, 1'b0);
    frame(1'b1, 12'h001, 8'h11, -1, 8, 1'b1);
    frame(1'b1, 12'h002, 8'h22, -1, 8, 1'b0);
    frame(1'b0, 12'h001, 8'h00, -1, 8, 1'b0);
    frame(1'b0, 12'h002, 8'h00, -1, 8, 1'b0);
    frame(1'b0, 12'h5A3, 8'h00, -1, 8, 1'b0);

    // Async reset in the middle of a write data phase.
    a = 12'h7F0;
    d = 8'hFF;
    c = wen_cnt;
    bus.mvalid = 1'b1;
    bus.mmode  = 1'b1;
    for (int k = 0; k < 15; k++) begin
      bus.mwdata = (k < 12) ? a[k] : d[k-12];
      @(negedge clk);
    end
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_rdy", bus.sready, 1);
    check("mid_rst_wen", mem_wen, 0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_wdata", mem_wdata, 0);
    bus.mvalid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("mid_rst_nowen", wen_cnt - c, 0);
    frame(1'b1, 12'h7F0, 8'h3C, -1, 8, 1'b0);
    frame(1'b0, 12'h7F0, 8'h00, -1, 8, 1'b0);

    for (int t = 0; t < 40; t++) begin
      w  = 1'($urandom_range(0, 1));
      a  = 12'h300 | 12'($urandom_range(0, 15));
      d  = 8'($urandom);
      c  = -1;
      rc = 8;
      if ($urandom_range(0, 5) == 0)
        c = w ? int'($urandom_range(1, 19)) : int'($urandom_range(1, 11));
      if (!w && $urandom_range(0, 5) == 0)
        rc = int'($urandom_range(1, 7));
      frame(w, a, d, c, rc, 1'($urandom_range(0, 1)));
    end
    bus.mvalid = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
